apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB requester (master) that converts single host-side read/write requests into APB transfers toward the slave1/slave2 responders on the peripheral bus.
- Runs a 3-state IDLE/SETUP/ACCESS FSM, decodes the target slave from one address bit, and honours PREADY wait states.
- Returns read data or a write completion on a one-cycle response strobe.
- Sits between the host/CPU request logic and the APB slaves, driving PSEL1/PSEL2, PENABLE, PWRITE, PADDR and PWDATA.

Parameters:
- ADDR_W, 8, APB address width.
- DATA_W, 8, APB data width.
- SEL_BIT, 7, PADDR bit that selects the slave: 0 = slave1, 1 = slave2.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort. Used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  bus clock; all logic on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- req_valid  in  1  host request present.
- req_ready  out  1  master can accept a request; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  timeout error flag, qualified by rsp_valid.
- PSEL1  out  1  select for slave1.
- PSEL2  out  1  select for slave2.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA1  in  DATA_W  slave1 read data.
- PRDATA2  in  DATA_W  slave2 read data.
- PREADY  in  1  OR of the slave ready signals.

Behaviour:
- Clocking and reset:
  - One clock, PCLK. Reset PRESET is synchronous and active-high.
  - Reset values: state IDLE; PSEL1/PSEL2/PENABLE/PWRITE = 0; PADDR/PWDATA = 0; rsp_valid/rsp_err = 0; rsp_rdata = 0; req_ready = 1 from the first cycle after reset.
- Request acceptance: a request is accepted on an edge with req_valid && req_ready.
  - That edge registers PADDR, PWDATA and PWRITE.
  - It asserts the decoded select: PSEL1 if req_addr[SEL_BIT] = 0, else PSEL2.
  - PENABLE stays 0. State moves to SETUP.
- SETUP: exactly one cycle, then ACCESS with PENABLE = 1.
- ACCESS: stay while PREADY = 0. PADDR, PWDATA, PWRITE and PSEL are held stable.
- Completion: on an edge with PREADY = 1 in ACCESS:
  - Drop PSEL*/PENABLE and return to IDLE.
  - Pulse rsp_valid for one cycle.
  - rsp_rdata = PRDATA of the selected slave for reads, 0 for writes. rsp_err = 0.
- Latency: accept at edge T; SETUP in cycle T+1; ACCESS in T+2; with a zero-wait slave, rsp_valid and req_ready are high in cycle T+3. N wait states add N cycles.
- Back-to-back transfers: none. IDLE lasts at least one cycle between transfers; a request held during the rsp_valid cycle is accepted on that edge.
- Bus values after a transfer: PADDR/PWDATA/PWRITE keep their last values; only PSEL*/PENABLE return to 0.
- PSEL1 and PSEL2 are never high together.
- Selection-bit corner: PREADY sampled outside ACCESS is ignored. PRDATA of the non-selected slave never reaches rsp_rdata.
- Reset mid-transfer: PRESET has priority in any state. The transfer is abandoned, no rsp_valid is produced, and outputs return to reset values on that edge.
- req_valid dropping while the master is busy has no effect: the request is already captured.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - An access counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY = 0.
  - When the count reaches TIMEOUT_CYCLES, the transfer aborts: PSEL*/PENABLE drop, state returns to IDLE, and the next cycle has rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
  - PREADY arriving on the same edge as the timeout wins (normal completion, rsp_err = 0).
- Undefined: no counter; ACCESS waits indefinitely; rsp_err is tied to 0.

Decomposition:
- Package apb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS);
  - the ADDR_W/DATA_W defaults;
  - the slave-index constants (SLV1 = 0, SLV2 = 1).
- One sub-module is natural: apb_addr_decode, combinational. It maps PADDR[SEL_BIT] to the PSEL1/PSEL2 one-hot and the PRDATA mux select.

Test Plan:
- Write to slave1: req_write=1, req_addr=8'h05, req_wdata=8'hA5, zero-wait PREADY -> PSEL1=1 for 2 cycles, PENABLE=1 in the 2nd, PADDR=8'h05, PWDATA=8'hA5; rsp_valid 3 cycles after accept; rsp_rdata=0.
- Read from slave2: req_addr=8'h85 with PRDATA2=8'h3C and PRDATA1=8'hFF -> only PSEL2 asserted; rsp_rdata=8'h3C.
- Wait states: PREADY held low for 4 ACCESS cycles -> PADDR/PWDATA/PSEL stable throughout; rsp_valid exactly 7 cycles after accept; req_ready low until then.
- Back-to-back: req_valid held high for two requests (8'h01 write, 8'h81 read) -> second accepted on the rsp_valid edge of the first; PSEL1 and PSEL2 never overlap.
- Reset mid-transfer: assert PRESET in the ACCESS cycle -> PSEL*/PENABLE = 0 the next cycle; no rsp_valid; req_ready=1.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and PREADY stuck low -> abort after 16 ACCESS cycles; rsp_valid=1, rsp_err=1, rsp_rdata=0; the next request completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester: FSM states, default bus widths
// and the slave index encoding used by the address decoder.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    localparam logic SLV1 = 1'b0;
    localparam logic SLV2 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slave decode: one address bit selects slave1 or slave2, giving the
// one-hot PSEL pair and the read-data mux index.
module apb_addr_decode
    import apb_pkg::*;
(
    input  logic sel_bit,
    output logic psel1,
    output logic psel2,
    output logic slv_idx
);

    always_comb begin
        slv_idx = sel_bit ? SLV2 : SLV1;
        psel1   = (slv_idx == SLV1);
        psel2   = (slv_idx == SLV2);
    end

endmodule

// File: rtl/apb_master.sv
// APB requester: turns single host read/write requests into IDLE/SETUP/ACCESS transfers
// toward two slaves. Optional ACCESS timeout abort is built when APB_TIMEOUT_EN is defined.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int SEL_BIT        = 7,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic [DATA_W-1:0] PRDATA2,
    input  logic              PREADY
);

    if (SEL_BIT >= ADDR_W || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_master: SEL_BIT must lie inside PADDR and TIMEOUT_CYCLES must be >= 1");
    end

    apb_state_t        state;
    apb_state_t        state_nxt;
    logic              accept;
    logic              done;
    logic              timeout;
    logic              dec_psel1;
    logic              dec_psel2;
    logic              slv_idx;
    logic [DATA_W-1:0] prdata_sel;

    // Decode from the registered address so the selects stay stable for the whole transfer.
    apb_addr_decode u_addr_decode (
        .sel_bit (PADDR[SEL_BIT]),
        .psel1   (dec_psel1),
        .psel2   (dec_psel2),
        .slv_idx (slv_idx)
    );

    assign req_ready  = (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign done       = (state == ACCESS) && PREADY;
    assign PENABLE    = (state == ACCESS);
    assign PSEL1      = (state != IDLE) && dec_psel1;
    assign PSEL2      = (state != IDLE) && dec_psel2;
    assign prdata_sel = (slv_idx == SLV2) ? PRDATA2 : PRDATA1;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] acc_cnt;
    logic             rsp_err_q;

    // Counts ACCESS cycles spent waiting; a PREADY on the final cycle still completes normally.
    assign timeout = (state == ACCESS) && !PREADY &&
                     (acc_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            acc_cnt   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= timeout;
            if (state == SETUP)
                acc_cnt <= '0;
            else if ((state == ACCESS) && !PREADY)
                acc_cnt <= acc_cnt + 1'b1;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (done || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address/data/direction persist after a transfer; only the selects and enable drop.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PADDR     <= '0;
            PWDATA    <= '0;
            PWRITE    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= done || timeout;
            rsp_rdata <= (done && !PWRITE) ? prdata_sel : '0;
            if (accept) begin
                PADDR  <= req_addr;
                PWDATA <= req_wdata;
                PWRITE <= req_write;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: writes, reads, wait states, back-to-back requests,
// reset mid-transfer and (with APB_TIMEOUT_EN) the timeout abort.
module tb_apb_master;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL1;
    logic              PSEL2;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA1;
    logic [DATA_W-1:0] PRDATA2;
    logic              PREADY;

    int n_assert = 0;
    int n_fail   = 0;

    apb_master #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .SEL_BIT        (7),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL1     (PSEL1),
        .PSEL2     (PSEL2),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA1   (PRDATA1),
        .PRDATA2   (PRDATA2),
        .PREADY    (PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_bus(input string tag);
        chk1({tag, "_psel1"}, PSEL1, 1'b0);
        chk1({tag, "_psel2"}, PSEL2, 1'b0);
        chk1({tag, "_penable"}, PENABLE, 1'b0);
        chk1({tag, "_req_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        PRDATA1   = 8'hFF;
        PRDATA2   = 8'h3C;
        PREADY    = 1'b0;
        tick();
        tick();
        PRESET = 1'b0;

        // Reset state
        chk_idle_bus("rst");
        chk1("rst_pwrite", PWRITE, 1'b0);
        chk8("rst_paddr", PADDR, 8'h00);
        chk8("rst_pwdata", PWDATA, 8'h00);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk8("rst_rsp_rdata", rsp_rdata, 8'h00);
        chk1("rst_rsp_err", rsp_err, 1'b0);

        // Write to slave1, zero wait; PREADY high outside ACCESS must be ignored
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h05; req_wdata = 8'hA5; PREADY = 1'b1;
        tick();
        req_valid = 1'b0;
        chk1("wr_setup_psel1", PSEL1, 1'b1);
        chk1("wr_setup_psel2", PSEL2, 1'b0);
        chk1("wr_setup_penable", PENABLE, 1'b0);
        chk1("wr_setup_pwrite", PWRITE, 1'b1);
        chk8("wr_setup_paddr", PADDR, 8'h05);
        chk8("wr_setup_pwdata", PWDATA, 8'hA5);
        chk1("wr_setup_req_ready", req_ready, 1'b0);
        chk1("wr_setup_rsp_valid", rsp_valid, 1'b0);
        tick();
        chk1("wr_access_psel1", PSEL1, 1'b1);
        chk1("wr_access_penable", PENABLE, 1'b1);
        chk1("wr_access_rsp_valid", rsp_valid, 1'b0);
        tick();
        chk1("wr_rsp_valid", rsp_valid, 1'b1);
        chk8("wr_rsp_rdata", rsp_rdata, 8'h00);
        chk1("wr_rsp_err", rsp_err, 1'b0);
        chk_idle_bus("wr_done");
        chk8("wr_done_paddr_kept", PADDR, 8'h05);
        chk8("wr_done_pwdata_kept", PWDATA, 8'hA5);
        tick();
        chk1("wr_rsp_one_cycle", rsp_valid, 1'b0);

        // Read from slave2; slave1 data must not leak through
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h85;
        tick();
        req_valid = 1'b0;
        chk1("rd_setup_psel2", PSEL2, 1'b1);
        chk1("rd_setup_psel1", PSEL1, 1'b0);
        chk1("rd_setup_pwrite", PWRITE, 1'b0);
        tick();
        chk1("rd_access_psel2", PSEL2, 1'b1);
        chk1("rd_access_penable", PENABLE, 1'b1);
        tick();
        chk1("rd_rsp_valid", rsp_valid, 1'b1);
        chk8("rd_rsp_rdata", rsp_rdata, 8'h3C);
        chk_idle_bus("rd_done");
        tick();

        // Four wait states: response 7 cycles after accept
        PREADY = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 8'h5A;
        tick();
        req_valid = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            tick();
            chk1("ws_penable", PENABLE, 1'b1);
            chk1("ws_psel1", PSEL1, 1'b1);
            chk1("ws_psel2", PSEL2, 1'b0);
            chk8("ws_paddr", PADDR, 8'h10);
            chk8("ws_pwdata", PWDATA, 8'h5A);
            chk1("ws_req_ready", req_ready, 1'b0);
            chk1("ws_rsp_valid", rsp_valid, 1'b0);
            if (k == 6) PREADY = 1'b1;
        end
        tick();
        chk1("ws_rsp_valid_c7", rsp_valid, 1'b1);
        chk1("ws_req_ready_c7", req_ready, 1'b1);
        chk8("ws_rsp_rdata", rsp_rdata, 8'h00);
        tick();

        // Back-to-back: request held high, second accepted on the first's response edge
        PRDATA2 = 8'h77;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h01; req_wdata = 8'h11;
        tick();
        chk1("b2b_a_psel1", PSEL1, 1'b1);
        chk1("b2b_a_psel2", PSEL2, 1'b0);
        req_write = 1'b0; req_addr = 8'h81;
        tick();
        chk1("b2b_a_access_psel1", PSEL1, 1'b1);
        chk1("b2b_a_access_psel2", PSEL2, 1'b0);
        tick();
        chk1("b2b_a_rsp_valid", rsp_valid, 1'b1);
        chk_idle_bus("b2b_a_done");
        tick();
        req_valid = 1'b0;
        chk1("b2b_b_psel2", PSEL2, 1'b1);
        chk1("b2b_b_psel1", PSEL1, 1'b0);
        chk8("b2b_b_paddr", PADDR, 8'h81);
        chk1("b2b_b_pwrite", PWRITE, 1'b0);
        chk1("b2b_b_rsp_valid", rsp_valid, 1'b0);
        tick();
        chk1("b2b_b_access_penable", PENABLE, 1'b1);
        chk1("b2b_b_access_psel1", PSEL1, 1'b0);
        tick();
        chk1("b2b_b_rsp_valid_done", rsp_valid, 1'b1);
        chk8("b2b_b_rsp_rdata", rsp_rdata, 8'h77);
        tick();

        // Reset during ACCESS abandons the transfer
        PREADY = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h22; req_wdata = 8'h33;
        tick();
        req_valid = 1'b0;
        tick();
        chk1("rstmid_access_penable", PENABLE, 1'b1);
        PRESET = 1'b1; PREADY = 1'b1;
        tick();
        PRESET = 1'b0; PREADY = 1'b0;
        chk_idle_bus("rstmid");
        chk1("rstmid_rsp_valid", rsp_valid, 1'b0);
        chk8("rstmid_paddr", PADDR, 8'h00);
        chk8("rstmid_pwdata", PWDATA, 8'h00);
        tick();
        chk1("rstmid_no_rsp", rsp_valid, 1'b0);
        chk1("rstmid_rsp_err", rsp_err, 1'b0);

`ifdef APB_TIMEOUT_EN
        // PREADY stuck low: abort after 16 ACCESS cycles
        PRDATA1 = 8'hC3;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h03;
        tick();
        req_valid = 1'b0;
        for (int k = 2; k <= 17; k++) begin
            tick();
            chk1("to_penable", PENABLE, 1'b1);
            chk1("to_rsp_valid", rsp_valid, 1'b0);
        end
        tick();
        chk1("to_rsp_valid_abort", rsp_valid, 1'b1);
        chk1("to_rsp_err", rsp_err, 1'b1);
        chk8("to_rsp_rdata", rsp_rdata, 8'h00);
        chk_idle_bus("to_done");
        tick();
        PREADY = 1'b1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk1("to_next_rsp_valid", rsp_valid, 1'b1);
        chk1("to_next_rsp_err", rsp_err, 1'b0);
        chk8("to_next_rsp_rdata", rsp_rdata, 8'hC3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
